axis_pixel_framer: RTL and testbench

Upstream input stage of the DNN accelerator. It accepts packed 8-bit image pixels on a 32-bit AXI-stream and unpacks them into the 16-bit, one-sample-per-beat stream consumed on `axis_in_data` / `axis_in_data_valid` / `axis_in_data_ready` of `nn_autoGen_top`. It enforces an exact FRAME_LEN-sample frame regardless of upstream framing: short frames are zero-padded and long frames are truncated. Both conditions are flagged.

---
 rtl/pixel_framer_pkg.sv | 21 ++
 rtl/pixel_framer_stats.sv | 43 ++++
 rtl/axis_pixel_framer.sv | 216 +++++++++++++++++++++
 tb/tb_axis_pixel_framer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_framer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_framer_pkg
//
// Shared definitions for the pixel framer:
//   - framer_state_e : framer state machine encoding (RUN, PAD, DROP)
//   - LANES          : pixels packed per 32-bit input word
//   - DEFAULT_*      : default frame length and pixel-to-sample shift
// -----------------------------------------------------------------------------
package pixel_framer_pkg;

    localparam int LANES             = 4;
    localparam int DEFAULT_FRAME_LEN = 784;
    localparam int DEFAULT_PIX_SHIFT = 7;

    typedef enum logic [1:0] {
        RUN  = 2'd0,  // unpacking real pixels
        PAD  = 2'd1,  // upstream ended early, emitting zeros to frame end
        DROP = 2'd2   // frame already complete, discarding until upstream tlast
    } framer_state_e;

endpackage

// File: rtl/pixel_framer_stats.sv
// -----------------------------------------------------------------------------
// pixel_framer_stats
//
// Two saturating event counters for the pixel framer.
//
// Ports:
//   clk          in   clock
//   resetn       in   synchronous active-low reset
//   frame_done   in   one-cycle pulse per completed frame
//   frame_err    in   one-cycle pulse per short or long frame error
//   frame_count  out  CNT_W  completed frames, saturating
//   error_count  out  CNT_W  framing errors, saturating
// -----------------------------------------------------------------------------
module pixel_framer_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_done,
    input  logic             frame_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count
);

    logic [1:0]       inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign inc = {frame_err, frame_done};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!resetn) begin
                cnt_reg[gi] <= '0;
            end else if (inc[gi] && (cnt_reg[gi] != '1)) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end
    end

    assign frame_count = cnt_reg[0];
    assign error_count = cnt_reg[1];

endmodule

// File: rtl/axis_pixel_framer.sv
// -----------------------------------------------------------------------------
// axis_pixel_framer
//
// Unpacks four 8-bit pixels per 32-bit AXI-stream word into a 16-bit,
// one-sample-per-beat stream and forces every frame to exactly FRAME_LEN
// samples: short frames are zero-padded, long frames are truncated.
//
// Optional feature macro: PIXEL_FRAMER_STATS_EN (frame/error counters).
// Without it frame_count and error_count are tied to 0.
//
// Ports:
//   s_axi_aclk         in   clock
//   s_axi_aresetn      in   synchronous active-low reset
//   s_axis_tdata       in   32   four pixels, lane 0 = [7:0] emitted first
//   s_axis_tvalid      in   input word valid
//   s_axis_tready      out  input word accepted on tvalid & tready
//   s_axis_tlast       in   last word of upstream frame
//   m_axis_data        out  DATA_WIDTH  pixel << PIX_SHIFT (0 while padding)
//   m_axis_data_valid  out  sample valid
//   m_axis_data_ready  in   downstream ready
//   frame_done         out  pulse on handshake of sample FRAME_LEN-1
//   err_short          out  pulse, cycle after a short frame is detected
//   err_long           out  pulse, cycle after a long frame is detected
//   frame_count        out  16  completed frames
//   error_count        out  16  short + long errors
// -----------------------------------------------------------------------------
module axis_pixel_framer
    import pixel_framer_pkg::*;
#(
    parameter int FRAME_LEN   = DEFAULT_FRAME_LEN,
    parameter int PIXEL_WIDTH = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int PIX_SHIFT   = DEFAULT_PIX_SHIFT
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_data_valid,
    input  logic                  m_axis_data_ready,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long,
    output logic [15:0]           frame_count,
    output logic [15:0]           error_count
);

    localparam int                IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [1:0]        LAST_LN  = 2'(LANES - 1);

    framer_state_e    state_reg, state_next;
    logic [31:0]      hold_reg, hold_next;
    logic             hold_valid_reg, hold_valid_next;
    logic             tlast_reg, tlast_next;
    logic [1:0]       lane_reg, lane_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             err_short_reg, err_short_next;
    logic             err_long_reg, err_long_next;

    logic [PIXEL_WIDTH-1:0] lane_pix [LANES];
    logic [DATA_WIDTH-1:0]  pix_ext;
    logic [DATA_WIDTH-1:0]  sample;

    logic out_valid;
    logic out_hs;
    logic in_hs;
    logic ready_int;
    logic run_ready;
    logic last_sample;
    logic last_lane;
    logic short_end;
    logic long_end;

    // Split the held word into its pixel lanes.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_pix[gi] = hold_reg[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    assign pix_ext = DATA_WIDTH'(lane_pix[lane_reg]);
    assign sample  = pix_ext << PIX_SHIFT;

    assign last_sample = (idx_reg == LAST_IDX);
    assign last_lane   = (lane_reg == LAST_LN);

    assign out_valid = ((state_reg == RUN) && hold_valid_reg) || (state_reg == PAD);
    assign out_hs    = out_valid && m_axis_data_ready;

    assign short_end = (state_reg == RUN) && last_lane && tlast_reg && !last_sample;
    assign long_end  = (state_reg == RUN) && last_lane && !tlast_reg && last_sample;

    // The lane-3 refill path keeps one sample per cycle. It is suppressed on
    // the handshake that ends a short or long frame: the next upstream word
    // belongs to the next frame (short case) or must be judged by DROP for
    // its tlast (long case), so it must not be swallowed here.
    assign run_ready = !hold_valid_reg
                     || (last_lane && out_hs && !short_end && !long_end);

    always_comb begin
        ready_int = 1'b0;
        case (state_reg)
            RUN:     ready_int = run_ready;
            DROP:    ready_int = 1'b1;
            default: ready_int = 1'b0;
        endcase
        // Held low throughout reset, independent of register contents.
        if (!s_axi_aresetn) begin
            ready_int = 1'b0;
        end
    end

    assign in_hs = s_axis_tvalid && ready_int;

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        tlast_next      = tlast_reg;
        lane_next       = lane_reg;
        idx_next        = idx_reg;
        err_short_next  = 1'b0;
        err_long_next   = 1'b0;

        if (out_hs) begin
            idx_next = last_sample ? '0 : idx_reg + IDX_W'(1);
        end

        case (state_reg)
            RUN: begin
                if (out_hs) begin
                    lane_next = lane_reg + 2'd1;
                    if (last_lane) begin
                        hold_valid_next = 1'b0;
                        if (short_end) begin
                            state_next     = PAD;
                            err_short_next = 1'b1;
                        end else if (long_end) begin
                            state_next    = DROP;
                            err_long_next = 1'b1;
                        end
                    end
                end
                // A same-cycle refill overrides the lane-3 clear above.
                if (in_hs) begin
                    hold_next       = s_axis_tdata;
                    hold_valid_next = 1'b1;
                    tlast_next      = s_axis_tlast;
                    lane_next       = 2'd0;
                end
            end
            PAD: begin
                if (out_hs && last_sample) begin
                    state_next = RUN;
                end
            end
            DROP: begin
                if (in_hs && s_axis_tlast) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_reg      <= RUN;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            tlast_reg      <= 1'b0;
            lane_reg       <= 2'd0;
            idx_reg        <= '0;
            err_short_reg  <= 1'b0;
            err_long_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            tlast_reg      <= tlast_next;
            lane_reg       <= lane_next;
            idx_reg        <= idx_next;
            err_short_reg  <= err_short_next;
            err_long_reg   <= err_long_next;
        end
    end

    assign s_axis_tready     = ready_int;
    assign m_axis_data_valid = out_valid;
    // Only RUN carries pixel data; PAD emits zeros and DROP is idle.
    assign m_axis_data       = (state_reg == RUN) ? sample : '0;
    assign frame_done        = out_hs && last_sample;
    assign err_short         = err_short_reg;
    assign err_long          = err_long_reg;

`ifdef PIXEL_FRAMER_STATS_EN
    pixel_framer_stats #(
        .CNT_W (16)
    ) u_stats (
        .clk         (s_axi_aclk),
        .resetn      (s_axi_aresetn),
        .frame_done  (frame_done),
        .frame_err   (err_short_reg | err_long_reg),
        .frame_count (frame_count),
        .error_count (error_count)
    );
`else
    assign frame_count = '0;
    assign error_count = '0;
`endif

endmodule

// File: tb/tb_axis_pixel_framer.sv
// -----------------------------------------------------------------------------
// tb_axis_pixel_framer
//
// Directed testbench for axis_pixel_framer: normal, backpressured, short,
// long, reset-mid-frame and statistics scenarios. Inputs change 1 ns after
// the rising edge; outputs are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_axis_pixel_framer;

    localparam int FRAME_LEN = 784;

    logic        clk;
    logic        resetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_done;
    logic        err_short;
    logic        err_long;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] first_samp [4];

    axis_pixel_framer #(
        .FRAME_LEN   (FRAME_LEN),
        .PIXEL_WIDTH (8),
        .DATA_WIDTH  (16),
        .PIX_SHIFT   (7)
    ) dut (
        .s_axi_aclk        (clk),
        .s_axi_aresetn     (resetn),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tlast      (s_tlast),
        .m_axis_data       (m_data),
        .m_axis_data_valid (m_valid),
        .m_axis_data_ready (m_ready),
        .frame_done        (frame_done),
        .err_short         (err_short),
        .err_long          (err_long),
        .frame_count       (frame_count),
        .error_count       (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Word w of a frame carries pixels (4w+1+seed), (4w+2+seed), ... in lanes 0..3.
    function automatic logic [31:0] word_of(input int w, input int seed);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*8 +: 8] = 8'((w*4 + k + 1 + seed) & 255);
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_sample(input int s, input int seed);
        return 16'(((s + 1 + seed) & 255) << 7);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ":tready"}, 32'(s_tready), 0);
        check_val({tag, ":valid"},  32'(m_valid), 0);
        check_val({tag, ":data"},   32'(m_data), 0);
        check_val({tag, ":done"},   32'(frame_done), 0);
        check_val({tag, ":eshort"}, 32'(err_short), 0);
        check_val({tag, ":elong"},  32'(err_long), 0);
        check_val({tag, ":fcnt"},   32'(frame_count), 0);
        check_val({tag, ":ecnt"},   32'(error_count), 0);
    endtask

    task automatic do_reset(input string tag, input int cycles);
        @(posedge clk);
        #1;
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_ready  = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            check_reset_outputs($sformatf("%s_c%0d", tag, i));
        end
        resetn = 1'b1;
    endtask

    // Drives one upstream frame and scores the output stream against the model.
    task automatic run_frame(input string name, input int nwords, input int seed,
                             input bit bp, input int abort_at,
                             input int exp_short, input int exp_long);
        int          sent, samp, extra, n_short, n_long, n_done, cyc, tail, real_n;
        bit          stalled, pad_ready, aborted;
        logic [15:0] stall_data;
        sent = 0; samp = 0; extra = 0; n_short = 0; n_long = 0; n_done = 0;
        cyc = 0; tail = 0; stalled = 0; pad_ready = 0; aborted = 0;
        stall_data = '0;
        real_n = (nwords * 4 < FRAME_LEN) ? nwords * 4 : FRAME_LEN;
        while (1) begin
            @(posedge clk);
            #1;
            s_tvalid = (sent < nwords);
            s_tdata  = (sent < nwords) ? word_of(sent, seed) : 32'h0;
            s_tlast  = (sent == nwords - 1);
            m_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                check_val($sformatf("%s:stall_valid@%0d", name, samp), 32'(m_valid), 1);
                check_val($sformatf("%s:stall_data@%0d", name, samp), 32'(m_data), 32'(stall_data));
            end
            n_short += int'(err_short);
            n_long  += int'(err_long);
            n_done  += int'(frame_done);
            if (samp >= real_n && samp < FRAME_LEN && s_tready) pad_ready = 1;
            if (m_valid && m_ready) begin
                if (samp < FRAME_LEN) begin
                    check_val($sformatf("%s:data[%0d]", name, samp), 32'(m_data),
                              32'((samp < real_n) ? exp_sample(samp, seed) : 16'h0));
                    check_val($sformatf("%s:done[%0d]", name, samp), 32'(frame_done),
                              32'(samp == FRAME_LEN - 1));
                    if (samp < 4) first_samp[samp] = m_data;
                    samp++;
                end else begin
                    extra++;
                end
            end
            stalled    = m_valid && !m_ready;
            stall_data = m_data;
            if (s_tvalid && s_tready) sent++;
            cyc++;
            if (abort_at > 0 && samp == abort_at) begin
                aborted = 1;
                break;
            end
            if (samp == FRAME_LEN && sent == nwords) begin
                tail++;
                if (tail > 4) break;
            end
            if (cyc > 20000) begin
                check_val({name, ":timeout"}, 32'(cyc), 0);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!aborted) begin
            check_val({name, ":samples"}, 32'(samp), FRAME_LEN);
            check_val({name, ":extra"}, 32'(extra), 0);
            check_val({name, ":done_cnt"}, 32'(n_done), 1);
            check_val({name, ":err_short"}, 32'(n_short), 32'(exp_short));
            check_val({name, ":err_long"}, 32'(n_long), 32'(exp_long));
            check_val({name, ":words"}, 32'(sent), 32'(nwords));
            check_val({name, ":pad_tready"}, 32'(pad_ready), 0);
        end
        $display("frame %s words=%0d accepted=%0d samples=%0d short=%0d long=%0d aborted=%0d",
                 name, nwords, sent, samp, n_short, n_long, aborted);
    endtask

    initial begin
        resetn   = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b1;

        // Reset state.
        do_reset("reset", 3);

        // 1. Normal frame, with hand-computed first samples.
        run_frame("normal", 196, 0, 0, 0, 0, 0);
        check_val("first0", 32'(first_samp[0]), 32'h0080);
        check_val("first1", 32'(first_samp[1]), 32'h0100);
        check_val("first2", 32'(first_samp[2]), 32'h0180);
        check_val("first3", 32'(first_samp[3]), 32'h0200);

        // 2. Backpressure.
        run_frame("backpressure", 196, 0, 1, 0, 0, 0);

        // 3. Short frame: 40 real samples then 744 zeros.
        run_frame("short", 10, 3, 0, 0, 1, 0);

        // 4. Long frame, then a normal frame starting from idx 0.
        run_frame("long", 200, 7, 0, 0, 0, 1);
        run_frame("after_long", 196, 11, 0, 0, 0, 0);

`ifdef PIXEL_FRAMER_STATS_EN
        check_val("stats_mid:fcnt", 32'(frame_count), 5);
        check_val("stats_mid:ecnt", 32'(error_count), 2);
`else
        check_val("stats_mid:fcnt", 32'(frame_count), 0);
        check_val("stats_mid:ecnt", 32'(error_count), 0);
`endif

        // 5. Reset mid-frame after 100 samples, then a clean frame.
        run_frame("partial", 196, 5, 0, 100, 0, 0);
        do_reset("midreset", 2);
        run_frame("after_reset", 196, 9, 0, 0, 0, 0);

        // 6. Statistics: normal, short, normal from a fresh reset.
        do_reset("stats_reset", 2);
        run_frame("stats_n1", 196, 20, 0, 0, 0, 0);
        run_frame("stats_short", 10, 21, 0, 0, 1, 0);
        run_frame("stats_n2", 196, 22, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
`ifdef PIXEL_FRAMER_STATS_EN
        check_val("stats:fcnt", 32'(frame_count), 3);
        check_val("stats:ecnt", 32'(error_count), 1);
`else
        check_val("stats:fcnt", 32'(frame_count), 0);
        check_val("stats:ecnt", 32'(error_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
